// File: rtl/upper_rsc_encoder.sv
// Turbo-code constituent encoder: 8-state RSC (g0=13, g1=15 octal) over an FL-bit frame,
// followed by three termination steps; the whole frame is presented in parallel.
module upper_rsc_encoder #(
    parameter int unsigned FL = 104,
    localparam int unsigned CW = $clog2(FL + 3)
) (
    input  logic          Clock,
    input  logic          nReset,
    input  logic          nClear,
    input  logic          Start,
    input  logic          In_Valid,
    input  logic          In_Bit,
    output logic          In_Ready,
    output logic          Busy,
    output logic          Frame_Valid,
    input  logic          Frame_Ack,
    output logic [FL-1:0] b1,
    output logic [FL+2:0] b2,
    output logic [2:0]    bt1
);

    typedef enum logic [1:0] {StIdle, StEncode, StTerm, StDone} state_e;

    localparam logic [CW-1:0] LastBit = CW'(FL - 1);
    localparam logic [CW-1:0] LastTerm = CW'(2);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    s_q, s_d;  // s_q[0]=s1, s_q[1]=s2, s_q[2]=s3
    logic [FL-1:0] b1_q, b1_d;
    logic [FL+2:0] b2_q, b2_d;
    logic [2:0]    bt1_q, bt1_d;
    logic          fv_q, fv_d;
    logic          fb, a;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        bt1_d   = bt1_q;
        fv_d    = fv_q;
        fb      = s_q[1] ^ s_q[2];
        a       = In_Bit ^ fb;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StEncode;
                    cnt_d   = '0;
                    s_d     = '0;
                    b1_d    = '0;
                    b2_d    = '0;
                    bt1_d   = '0;
                end
            end
            StEncode: begin
                if (In_Valid) begin
                    for (int i = 0; i < int'(FL); i++) begin
                        if (cnt_q == CW'(i)) begin
                            b1_d[i] = In_Bit;
                            b2_d[i] = a ^ s_q[0] ^ s_q[2];
                        end
                    end
                    s_d = {s_q[1], s_q[0], a};
                    if (cnt_q == LastBit) begin
                        state_d = StTerm;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StTerm: begin
                // Input chosen equal to the feedback, so the register input a is zero.
                for (int j = 0; j < 3; j++) begin
                    if (cnt_q == CW'(j)) begin
                        bt1_d[j]    = fb;
                        b2_d[FL+j]  = s_q[0] ^ s_q[2];
                    end
                end
                s_d = {s_q[1], s_q[0], 1'b0};
                if (cnt_q == LastTerm) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    fv_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                if (Start) begin
                    state_d = StEncode;
                    cnt_d   = '0;
                    s_d     = '0;
                    b1_d    = '0;
                    b2_d    = '0;
                    bt1_d   = '0;
                    fv_d    = 1'b0;
                end else if (Frame_Ack) begin
                    state_d = StIdle;
                    fv_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!nClear) begin
            state_d = StIdle;
            cnt_d   = '0;
            s_d     = '0;
            b1_d    = '0;
            b2_d    = '0;
            bt1_d   = '0;
            fv_d    = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            s_q     <= '0;
            b1_q    <= '0;
            b2_q    <= '0;
            bt1_q   <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            bt1_q   <= bt1_d;
            fv_q    <= fv_d;
        end
    end

    assign In_Ready    = (state_q == StEncode);
    assign Busy        = (state_q == StEncode) || (state_q == StTerm);
    assign Frame_Valid = fv_q;
    assign b1          = b1_q;
    assign b2          = b2_q;
    assign bt1         = bt1_q;

    // Termination must always land the trellis in the all-zero state.
    a_term_zero: assert property (@(posedge Clock) disable iff (!nReset)
        (state_q == StDone) |-> (s_q == 3'b000));

endmodule
